// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply/divide unit for the EX stage.
// Accepts one op from ID/EX, stalls the front end for XLEN iterations,
// then presents a single-cycle result pulse toward EX/MEM.
module ex_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5   // must equal clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid_EX,
  input  logic [1:0]      i_op_EX,
  input  logic [XLEN-1:0] i_dataA_EX,
  input  logic [XLEN-1:0] i_dataB_EX,
  input  logic [4:0]      i_addr_des_EX,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_result_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_addr_des
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN - 1);

  // op encoding: bit 1 selects divide, bit 0 selects high word / remainder
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     a_q, a_d;          // multiplicand
  logic [XLEN-1:0]     b_q, b_d;          // divisor
  logic [1:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;    // {partial product, remaining multiplier}
  logic [XLEN-1:0]     rem_q, rem_d;      // restored remainder, always < divisor
  logic [XLEN-1:0]     quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          addr_des_q, addr_des_d;

  // Datapath step values for the current iteration
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift;         // XLEN+1 bit partial remainder
  logic [XLEN:0]       div_diff;
  logic [XLEN-1:0]     rem_next;
  logic [XLEN-1:0]     quo_next;
  logic                accept;

  // Shift-add multiply step and restoring divide step
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]};
    if (prod_q[0]) begin
      mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
    end
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};

    div_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    // A set top bit means the trial subtraction went negative: restore
    rem_next  = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    quo_next  = {quo_q[XLEN-2:0], ~div_diff[XLEN]};
  end

  // Next-state and output decode
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    rd_d           = rd_q;
    prod_d         = prod_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    result_d       = result_q;
    addr_des_d     = addr_des_q;
    o_stall        = 1'b0;
    o_result_valid = 1'b0;
    accept         = i_valid_EX & ~i_flush;

    unique case (state_q)
      StIdle: begin
        o_stall = accept;
        if (accept) begin
          a_d    = i_dataA_EX;
          b_d    = i_dataB_EX;
          op_d   = i_op_EX;
          rd_d   = i_addr_des_EX;
          cnt_d  = '0;
          prod_d = {{XLEN{1'b0}}, i_dataB_EX};
          rem_d  = '0;
          quo_d  = i_dataA_EX;
          if (i_op_EX[1] && (i_dataB_EX == '0)) begin
            // Divide by zero resolves without iterating
            state_d    = StDone;
            result_d   = i_op_EX[0] ? i_dataA_EX : '1;
            addr_des_d = i_addr_des_EX;
          end else begin
            state_d = StBusy;
          end
        end
      end

      StBusy: begin
        if (i_flush) begin
          state_d = StIdle;
        end else begin
          o_stall = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (op_q[1]) begin
            rem_d = rem_next;
            quo_d = quo_next;
          end else begin
            prod_d = mul_next;
          end
          if (cnt_q == CntLast) begin
            state_d    = StDone;
            addr_des_d = rd_q;
            if (op_q[1]) begin
              result_d = op_q[0] ? rem_next : quo_next;
            end else begin
              result_d = op_q[0] ? mul_next[2*XLEN-1:XLEN] : mul_next[XLEN-1:0];
            end
          end
        end
      end

      StDone: begin
        // ID/EX still shows the completing op here, so i_valid_EX is ignored
        o_result_valid = ~i_flush;
        state_d        = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      result_q   <= '0;
      addr_des_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      result_q   <= result_d;
      addr_des_q <= addr_des_d;
    end
  end

  assign o_busy     = (state_q != StIdle);
  assign o_result   = result_q;
  assign o_addr_des = addr_des_q;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage.
- Reads operands, opcode and destination address from the ID/EX pipeline register outputs.
- Holds the front of the pipeline with `o_stall` while it iterates, then presents one result with a single-cycle valid to the EX/MEM path.
- It is the consumer end of the ID/EX interface and supplies back-pressure to the IF/ID and ID/EX registers through their enables.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width; must equal clog2(XLEN).

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_valid_EX  input  1  ID/EX holds a mul/div instruction
- i_op_EX  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU; all unsigned
- i_dataA_EX  input  XLEN  operand A / dividend
- i_dataB_EX  input  XLEN  operand B / divisor
- i_addr_des_EX  input  5  destination register (rd)
- i_flush  input  1  kill the in-flight operation (branch/jump redirect)
- o_stall  output  1  freeze IF/ID and ID/EX (drive their en low)
- o_busy  output  1  FSM not in IDLE
- o_result_valid  output  1  one-cycle pulse, result and rd valid
- o_result  output  XLEN  result
- o_addr_des  output  5  rd of the result

Behaviour:
- Reset (async assert, sync release): state=IDLE, counter=0, all internal accumulators=0. Outputs: o_stall=0, o_busy=0, o_result_valid=0, o_result=0, o_addr_des=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - o_stall = i_valid_EX & ~i_flush (combinational).
  - On i_valid_EX & ~i_flush: latch A, B, op, rd; counter<=0.
  - If op is DIVU/REMU with B==0, go directly to DONE. Otherwise go to BUSY.
- BUSY:
  - o_stall=1. One iteration per cycle; counter increments.
  - At counter==XLEN-1, go to DONE. This gives exactly XLEN BUSY cycles.
  - Multiply: shift-add on a 2*XLEN product register. MUL returns product[XLEN-1:0]; MULHU returns product[2*XLEN-1:XLEN].
  - Divide: restoring division with an XLEN+1 bit partial remainder. DIVU returns the quotient; REMU returns the remainder.
- DONE:
  - o_stall=0, o_result_valid=1, o_result and o_addr_des driven from registers. Always returns to IDLE next cycle.
  - i_valid_EX is ignored in DONE: ID/EX still shows the completing instruction and captures the next one at the end of this cycle.
- Divide by zero: DIVU result = all ones (0xFFFFFFFF); REMU result = dividend. Total stall is 1 cycle.
- Latency for a normal op, counting the accept cycle as 1: o_stall is high for cycles 1..XLEN+1 (33); o_result_valid is high in cycle XLEN+2 (34).
- o_busy = (state != IDLE).
- o_result and o_addr_des hold their last value outside DONE. Consumers must qualify them with o_result_valid.
- i_flush in BUSY or DONE: next state IDLE, no o_result_valid pulse, o_stall drops in the same cycle (combinational). i_flush in IDLE masks acceptance. Flush has priority over every other transition.
- Reset mid-operation: immediate abort, no result pulse after release.
- Back-to-back ops: after DONE→IDLE, a new i_valid_EX in that IDLE cycle is accepted normally. Minimum spacing is one IDLE cycle.

Test Plan:
- Reset during BUSY at counter=10 → all outputs 0 immediately; no o_result_valid after release; the next op completes correctly.
- MUL A=7, B=6 → o_stall high for 33 cycles; o_result_valid for 1 cycle in cycle 34 with o_result=42 and o_addr_des equal to the rd that was latched.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF → o_result=0xFFFFFFFE. MUL with the same operands → o_result=0x00000001.
- DIVU 100/7 → o_result=14. REMU 100/7 → o_result=2. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5, with a 1-cycle stall and the pulse in cycle 2.
- i_flush asserted at BUSY counter=5 → o_stall low the same cycle, state IDLE, no o_result_valid pulse. A following DIVU 9/3 → 3.
- Two back-to-back ops: MUL 3×3, then DIVU 81/9 → two pulses, results 9 then 9, each with its own rd; the stale i_valid_EX during DONE does not start a third op.
